// File: rtl/interval_timer_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : interval_timer_ctrl
//  Purpose  : Programmable interval timer controller. A WIDTH-bit up counter
//             advances once every (prescale+1) clocks while running and
//             expires when it reaches the programmed limit. It can run in
//             one-shot or periodic mode, and it drives a sticky interrupt
//             with acknowledge and overrun detection.
//  Ports    :
//    clk           - clock, all state changes on the rising edge
//    reset         - asynchronous, active-high reset
//    cfg_valid     - configuration offered
//    cfg_ready     - configuration can be accepted (not running)
//    cfg_limit     - terminal count value
//    cfg_prescale  - counter advances every cfg_prescale+1 cycles
//    cfg_periodic  - 1 = auto-reload on expiry, 0 = one-shot
//    start         - begin counting from 0 (ignored while running)
//    stop          - halt counting (only while running)
//    busy          - running
//    count         - current counter value
//    expire        - one-cycle registered pulse per expiry
//    irq           - sticky interrupt, cleared by irq_ack
//    irq_ack       - interrupt acknowledge
//    overrun       - sticky: an expiry occurred while irq was still pending
//  Revision : 1.0 - initial release
// ============================================================================
module interval_timer_ctrl #(
  parameter int WIDTH      = 32,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [WIDTH-1:0]      cfg_limit,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  input  logic                  cfg_periodic,
  input  logic                  start,
  input  logic                  stop,
  output logic                  busy,
  output logic [WIDTH-1:0]      count,
  output logic                  expire,
  output logic                  irq,
  input  logic                  irq_ack,
  output logic                  overrun
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_q,    state_d;
  logic [WIDTH-1:0]      count_q,    count_d;
  logic [WIDTH-1:0]      limit_q,    limit_d;
  logic [PRESCALE_W-1:0] presc_q,    presc_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  periodic_q, periodic_d;
  logic                  expire_q,   expire_d;
  logic                  irq_q,      irq_d;
  logic                  overrun_q,  overrun_d;

  logic running;
  logic cfg_xfer;
  logic tick;
  logic expiry;

  // Configuration is only accepted while the counter is not running, so the
  // stored limit/prescale can never change underneath an active count.
  assign running  = (state_q == ST_RUN);
  assign cfg_xfer = cfg_valid && !running;

  // A tick is the edge at which the prescaler wraps; the counter only moves
  // on ticks. Expiry is a tick that finds the counter already at the limit,
  // which is what keeps count from ever exceeding limit.
  assign tick     = running && (presc_q == prescale_q);
  assign expiry   = tick && (count_q == limit_q);

  // --------------------------------------------------------------------------
  // State register and datapath flops
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      limit_q    <= '0;
      presc_q    <= '0;
      prescale_q <= '0;
      periodic_q <= 1'b0;
      expire_q   <= 1'b0;
      irq_q      <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      limit_q    <= limit_d;
      presc_q    <= presc_d;
      prescale_q <= prescale_d;
      periodic_q <= periodic_d;
      expire_q   <= expire_d;
      irq_q      <= irq_d;
      overrun_q  <= overrun_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    limit_d    = limit_q;
    presc_d    = presc_q;
    prescale_d = prescale_q;
    periodic_d = periodic_q;

    case (state_q)
      ST_RUN: begin
        if (expiry) begin
          // An expiry is always fully processed, even when stop arrives on
          // the same edge; stop then only overrides where we end up.
          presc_d = '0;
          if (periodic_q) begin
            count_d = '0;
          end else begin
            state_d = ST_DONE;
          end
          if (stop) begin
            state_d = ST_IDLE;
          end
        end else if (stop) begin
          // Count and prescaler freeze in place so software can read where
          // the timer was halted.
          state_d = ST_IDLE;
        end else if (tick) begin
          presc_d = '0;
          count_d = count_q + WIDTH'(1);
        end else begin
          presc_d = presc_q + PRESCALE_W'(1);
        end
      end

      default: begin
        // IDLE, DONE (and any unreachable encoding) behave alike: accept a
        // configuration and/or a start. Start uses the configuration written
        // on the same edge because the new values land in the same flops.
        if (cfg_xfer) begin
          limit_d    = cfg_limit;
          prescale_d = cfg_prescale;
          periodic_d = cfg_periodic;
          count_d    = '0;
          presc_d    = '0;
        end
        if (start) begin
          state_d = ST_RUN;
          count_d = '0;
          presc_d = '0;
        end
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Interrupt, overrun and expire pulse
  // --------------------------------------------------------------------------
  always_comb begin
    expire_d  = expiry;
    irq_d     = irq_q;
    overrun_d = overrun_q;

    if (expiry) begin
      // Setting irq takes priority over an acknowledge on the same edge; the
      // acknowledge still clears overrun because software has now seen it.
      irq_d = 1'b1;
      if (irq_q && !irq_ack) begin
        overrun_d = 1'b1;
      end else if (irq_ack) begin
        overrun_d = 1'b0;
      end
    end else if (irq_ack) begin
      irq_d     = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign cfg_ready = !running;
  assign busy      = running;
  assign count     = count_q;
  assign expire    = expire_q;
  assign irq       = irq_q;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire
